// File: rtl/musa_mem_arbiter_if.sv
// Request/response bus between the fetch unit, the load/store unit, the shared
// single-port memory and the arbiter that sits between them.
interface musa_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/musa_mem_arbiter.sv
// Single-port memory arbiter for the multi-cycle core: data port has priority,
// a wait counter forces a fetch grant after STARVE_LIM lost arbitrations.
module musa_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    musa_mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);
    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  wait_cnt_r, wait_nxt_s;
    logic [LAT_W-1:0]  lat_cnt_r, lat_nxt_s;
    logic              owner_d_r, owner_d_nxt_s;
    logic              store_r, store_nxt_s;
    logic              d_win_s, f_win_s;

    logic              if_gnt_r, if_gnt_nxt_s;
    logic              if_valid_r, if_valid_nxt_s;
    logic [DATA_W-1:0] if_rdata_r, if_rdata_nxt_s;
    logic              d_gnt_r, d_gnt_nxt_s;
    logic              d_valid_r, d_valid_nxt_s;
    logic [DATA_W-1:0] d_rdata_r, d_rdata_nxt_s;
    logic              mem_en_r, mem_en_nxt_s;
    logic              mem_we_r, mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic              busy_r, busy_nxt_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Arbitration, next state and next values of every registered output
    always_comb begin
        d_win_s         = bus.d_req && (!bus.if_req || (wait_cnt_r < STARVE_MAX));
        f_win_s         = bus.if_req && !d_win_s;
        state_nxt_s     = state_r;
        wait_nxt_s      = wait_cnt_r;
        lat_nxt_s       = lat_cnt_r;
        owner_d_nxt_s   = owner_d_r;
        store_nxt_s     = store_r;
        if_gnt_nxt_s    = 1'b0;
        if_valid_nxt_s  = 1'b0;
        if_rdata_nxt_s  = if_rdata_r;
        d_gnt_nxt_s     = 1'b0;
        d_valid_nxt_s   = 1'b0;
        d_rdata_nxt_s   = d_rdata_r;
        mem_en_nxt_s    = 1'b0;
        mem_we_nxt_s    = 1'b0;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (d_win_s || f_win_s) begin
                    state_nxt_s     = ST_ACCESS;
                    owner_d_nxt_s   = d_win_s;
                    store_nxt_s     = d_win_s && bus.d_we;
                    mem_en_nxt_s    = 1'b1;
                    mem_we_nxt_s    = d_win_s && bus.d_we;
                    mem_addr_nxt_s  = d_win_s ? bus.d_addr : bus.if_addr;
                    mem_wdata_nxt_s = d_win_s ? bus.d_wdata : {DATA_W{1'b0}};
                    d_gnt_nxt_s     = d_win_s;
                    if_gnt_nxt_s    = f_win_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
                // A pending fetch that loses only ever happens below the limit, so this saturates
                if (f_win_s) begin
                    wait_nxt_s = {CNT_W{1'b0}};
                end else if (d_win_s && bus.if_req) begin
                    wait_nxt_s = wait_cnt_r + CNT_W'(1);
                end else begin
                    wait_nxt_s = wait_cnt_r;
                end
            end
            ST_ACCESS: begin
                state_nxt_s = ST_WAIT;
                lat_nxt_s   = LAT_INIT;
            end
            ST_WAIT: begin
                if (lat_cnt_r == {LAT_W{1'b0}}) begin
                    state_nxt_s = ST_RESP;
                    if (owner_d_r) begin
                        d_valid_nxt_s = 1'b1;
                        if (!store_r) begin
                            d_rdata_nxt_s = bus.mem_rdata;
                        end else begin
                            d_rdata_nxt_s = d_rdata_r;
                        end
                    end else begin
                        if_valid_nxt_s = 1'b1;
                        if_rdata_nxt_s = bus.mem_rdata;
                    end
                end else begin
                    lat_nxt_s = lat_cnt_r - LAT_W'(1);
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // Bookkeeping and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r  <= {CNT_W{1'b0}};
            lat_cnt_r   <= {LAT_W{1'b0}};
            owner_d_r   <= 1'b0;
            store_r     <= 1'b0;
            if_gnt_r    <= 1'b0;
            if_valid_r  <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            d_gnt_r     <= 1'b0;
            d_valid_r   <= 1'b0;
            d_rdata_r   <= {DATA_W{1'b0}};
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            wait_cnt_r  <= wait_nxt_s;
            lat_cnt_r   <= lat_nxt_s;
            owner_d_r   <= owner_d_nxt_s;
            store_r     <= store_nxt_s;
            if_gnt_r    <= if_gnt_nxt_s;
            if_valid_r  <= if_valid_nxt_s;
            if_rdata_r  <= if_rdata_nxt_s;
            d_gnt_r     <= d_gnt_nxt_s;
            d_valid_r   <= d_valid_nxt_s;
            d_rdata_r   <= d_rdata_nxt_s;
            mem_en_r    <= mem_en_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign bus.if_gnt    = if_gnt_r;
    assign bus.if_valid  = if_valid_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_gnt     = d_gnt_r;
    assign bus.d_valid   = d_valid_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_musa_mem_arbiter.sv
// Directed bench for musa_mem_arbiter (MEM_LAT=1, STARVE_LIM=4) with a small
// behavioural memory; expected values are hand-computed per vector.
module tb_musa_mem_arbiter;
    logic clk;
    logic rst_n;
    int   total_cnt;
    int   bad_cnt;

    musa_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    musa_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIM(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: word-addressed, one cycle read latency
    logic [31:0] mem_model [0:255];
    logic [31:0] rd_q;
    assign bus.mem_rdata = rd_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 32'hA000_0000 + i;
        mem_model[16] = 32'h2008_0005;
        rd_q = 32'h0;
    end

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem_model[bus.mem_addr[9:2]] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) rd_q <= mem_model[bus.mem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction starting from an IDLE cycle, nothing else requesting
    task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd,
                           input logic [31:0] other_rd, input string tag);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        cyc();
        chk({tag, "_mem_en"}, bus.mem_en, 1'b1);
        chk({tag, "_mem_we"}, bus.mem_we, we);
        chk({tag, "_mem_addr"}, bus.mem_addr, addr);
        chk({tag, "_gnt"}, is_d ? bus.d_gnt : bus.if_gnt, 1'b1);
        chk({tag, "_busy"}, bus.busy, 1'b1);
        if (we) chk({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        bus.d_addr = 32'hFFFF_FFF0; bus.if_addr = 32'hFFFF_FFF0; bus.d_wdata = 32'h0;
        cyc();
        chk({tag, "_wait_en"}, bus.mem_en, 1'b0);
        cyc();
        chk({tag, "_valid"}, is_d ? bus.d_valid : bus.if_valid, 1'b1);
        chk({tag, "_other_valid"}, is_d ? bus.if_valid : bus.d_valid, 1'b0);
        chk({tag, "_rdata"}, is_d ? bus.d_rdata : bus.if_rdata, exp_rd);
        chk({tag, "_other_rdata"}, is_d ? bus.if_rdata : bus.d_rdata, other_rd);
        cyc();
        chk({tag, "_idle_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        total_cnt = 0; bad_cnt = 0;
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        cyc(); cyc();
        chk("rst_outs", {bus.if_gnt, bus.if_valid, bus.d_gnt, bus.d_valid,
                         bus.mem_en, bus.mem_we, bus.busy}, 7'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_no_req", {bus.mem_en, bus.busy}, 2'b00);
        end

        // Fetch, then store, then load back the stored word
        run_txn(1'b0, 1'b0, 32'h40, 32'h0, 32'h2008_0005, 32'h0, "fetch");
        run_txn(1'b1, 1'b1, 32'h100, 32'hDEAD, 32'h0, 32'h2008_0005, "store");
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD, 32'h2008_0005, "load");

        // Contention: four data grants, then fetch wins
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("cont_d_gnt", bus.d_gnt, (k < 4) ? 1'b1 : 1'b0);
            chk("cont_if_gnt", bus.if_gnt, (k < 4) ? 1'b0 : 1'b1);
            chk("cont_wait_cnt", 32'(dut.wait_cnt_r), (k < 4) ? 32'(k + 1) : 32'd0);
            if (k == 4) bus.if_req = 1'b0;
            cyc();
            cyc();
            if (k < 4) chk("cont_d_rdata", bus.d_rdata, 32'hA000_0020);
            else       chk("cont_if_rdata", bus.if_rdata, 32'hA000_0011);
            if (k == 4) bus.d_req = 1'b0;
            cyc();
        end

        // Request raised during WAIT is served only after RESP
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        cyc();
        chk("late_d_gnt", bus.d_gnt, 1'b1);
        bus.d_req = 1'b0;
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 32'h48;
        chk("late_wait_en", bus.mem_en, 1'b0);
        cyc();
        chk("late_resp_en", {bus.mem_en, bus.if_gnt}, 2'b00);
        chk("late_d_valid", bus.d_valid, 1'b1);
        cyc();
        chk("late_idle_en", bus.mem_en, 1'b0);
        cyc();
        chk("late_if_gnt", {bus.if_gnt, bus.mem_en}, 2'b11);
        chk("late_mem_addr", bus.mem_addr, 32'h48);
        bus.if_req = 1'b0;
        cyc(); cyc();
        chk("late_if_rdata", bus.if_rdata, 32'hA000_0012);
        cyc();

        // Reset pulsed in WAIT of a load
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
        cyc();
        bus.d_req = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {bus.busy, bus.mem_en, bus.d_gnt}, 3'b000);
        chk("abort_d_rdata", bus.d_rdata, 32'h0);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("abort_no_valid", {bus.d_valid, bus.busy}, 2'b00);
        run_txn(1'b1, 1'b0, 32'h44, 32'h0, 32'hA000_0011, 32'h0, "post_rst");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
